data_mem_ctrl: RTL and testbench

- Data-side memory controller directly downstream of the processor's memory stages.
- Consumes DataAddr/DataOut/WriteData/ReadData, which the processor drives during its Memory1 cycle.
- Returns DataIn/DataDone in time for the Memory3 capture.
- Contains on-chip word RAM, a memory-mapped LEDR register, a synchronised SW input, a free-running cycle counter and a sticky address-error flag.

---
 rtl/data_mem_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_data_mem_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_ctrl
// Purpose  : Data-side memory controller sitting behind the processor's
//            memory stages. Holds the on-chip word RAM plus a small MMIO
//            block (LEDR register, synchronised switches, free-running
//            cycle counter) and a sticky illegal-access flag. Loads have a
//            fixed two-cycle latency and are fully pipelined; stores commit
//            at the edge that ends the request cycle.
// Ports    : Clock     - system clock, rising edge
//            Reset     - asynchronous, active-high reset
//            DataAddr  - word address of the request
//            DataOut   - store data from the processor
//            WriteData - store request this cycle
//            ReadData  - load request this cycle
//            SW        - raw board switches (asynchronous)
//            DataIn    - load result (zero when DataDone is low)
//            DataDone  - DataIn valid this cycle
//            LEDR      - LED register, low 10 bits
//            MemError  - sticky illegal-access flag, cleared only by Reset
// Revision : 1.0 - initial release
// ============================================================================
module data_mem_ctrl #(
  parameter int                   WORD_SIZE = 16,
  parameter int                   DEPTH     = 256,
  parameter logic [WORD_SIZE-1:0] LED_ADDR  = 16'h1000,
  parameter logic [WORD_SIZE-1:0] CNT_ADDR  = 16'h2000,
  parameter logic [WORD_SIZE-1:0] SW_ADDR   = 16'h3000
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic [WORD_SIZE-1:0] DataAddr,
  input  logic [WORD_SIZE-1:0] DataOut,
  input  logic                 WriteData,
  input  logic                 ReadData,
  input  logic [9:0]           SW,
  output logic [WORD_SIZE-1:0] DataIn,
  output logic                 DataDone,
  output logic [9:0]           LEDR,
  output logic                 MemError
);

  localparam int                 c_addr_w    = $clog2(DEPTH);
  localparam logic [WORD_SIZE:0] c_depth_ext = (WORD_SIZE+1)'(DEPTH);

  // Region select carried down the read pipeline.
  localparam logic [1:0] c_sel_ram  = 2'd0;
  localparam logic [1:0] c_sel_mmio = 2'd1;
  localparam logic [1:0] c_sel_none = 2'd2;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [WORD_SIZE-1:0] r_ram [DEPTH];
  logic [WORD_SIZE-1:0] r_counter;
  logic [9:0]           r_ledr;
  logic                 r_mem_error;
  logic [9:0]           r_sw_meta;
  logic [9:0]           r_sw_sync;

  // Read pipeline stage 1
  logic                 r_s1_valid;
  logic [1:0]           r_s1_sel;
  logic [WORD_SIZE-1:0] r_s1_mmio;
  logic [WORD_SIZE-1:0] r_s1_ram_q;

  // Read pipeline stage 2 (drives the outputs directly)
  logic                 r_s2_valid;
  logic [WORD_SIZE-1:0] r_s2_data;

  // --------------------------------------------------------------------------
  // Request decode
  // --------------------------------------------------------------------------
  logic                 w_is_ram;
  logic                 w_is_led;
  logic                 w_is_cnt;
  logic                 w_is_sw;
  logic                 w_legal;
  logic [c_addr_w-1:0]  w_ram_idx;
  logic                 w_ram_we;
  logic                 w_ram_re;
  logic                 w_led_we;
  logic                 w_cnt_we;
  logic                 w_err_set;
  logic [1:0]           w_sel;
  logic [WORD_SIZE-1:0] w_mmio_val;
  logic [WORD_SIZE-1:0] w_s2_next;

  always_comb begin
    w_is_ram  = ({1'b0, DataAddr} < c_depth_ext);
    w_is_led  = (DataAddr == LED_ADDR);
    w_is_cnt  = (DataAddr == CNT_ADDR);
    w_is_sw   = (DataAddr == SW_ADDR);
    w_legal   = w_is_ram | w_is_led | w_is_cnt | w_is_sw;

    // Only meaningful once w_is_ram has qualified the address.
    w_ram_idx = DataAddr[c_addr_w-1:0];

    w_ram_we  = WriteData & w_is_ram;
    w_ram_re  = ReadData  & w_is_ram;
    w_led_we  = WriteData & w_is_led;
    w_cnt_we  = WriteData & w_is_cnt;

    // Simultaneous load/store is serviced but still flagged; stores to the
    // read-only switch port and any access outside the map are flagged too.
    w_err_set = (WriteData & ReadData)
              | (WriteData & (w_is_sw | ~w_legal))
              | (ReadData  & ~w_legal);

    if (w_is_ram) begin
      w_sel = c_sel_ram;
    end else if (w_legal) begin
      w_sel = c_sel_mmio;
    end else begin
      w_sel = c_sel_none;
    end

    // MMIO values are captured in the request cycle, before any store in
    // that same cycle lands, which gives read-before-write for free.
    w_mmio_val = '0;
    if (w_is_led) begin
      w_mmio_val = {{(WORD_SIZE-10){1'b0}}, r_ledr};
    end else if (w_is_cnt) begin
      w_mmio_val = r_counter;
    end else if (w_is_sw) begin
      w_mmio_val = {{(WORD_SIZE-10){1'b0}}, r_sw_sync};
    end
  end

  // --------------------------------------------------------------------------
  // Word RAM: no reset on the array. The read port is sampled at the request
  // edge, so a same-cycle store is not yet visible (read-before-write) while
  // a store in the previous cycle already is (read-after-write).
  // --------------------------------------------------------------------------
  always_ff @(posedge Clock) begin
    if (w_ram_we) begin
      r_ram[w_ram_idx] <= DataOut;
    end
    if (w_ram_re) begin
      r_s1_ram_q <= r_ram[w_ram_idx];
    end
  end

  // --------------------------------------------------------------------------
  // Read pipeline
  // --------------------------------------------------------------------------
  always_comb begin
    w_s2_next = '0;
    if (r_s1_valid) begin
      case (r_s1_sel)
        c_sel_ram:  w_s2_next = r_s1_ram_q;
        c_sel_mmio: w_s2_next = r_s1_mmio;
        default:    w_s2_next = '0;
      endcase
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_s1_valid <= 1'b0;
      r_s1_sel   <= c_sel_none;
      r_s1_mmio  <= '0;
      r_s2_valid <= 1'b0;
      r_s2_data  <= '0;
    end else begin
      r_s1_valid <= ReadData;
      r_s1_sel   <= w_sel;
      r_s1_mmio  <= w_mmio_val;
      r_s2_valid <= r_s1_valid;
      r_s2_data  <= w_s2_next;
    end
  end

  // --------------------------------------------------------------------------
  // MMIO registers, switch synchroniser and error flag
  // --------------------------------------------------------------------------
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_counter   <= '0;
      r_ledr      <= '0;
      r_mem_error <= 1'b0;
      r_sw_meta   <= '0;
      r_sw_sync   <= '0;
    end else begin
      // A store to the counter clears it and suppresses that edge's increment.
      if (w_cnt_we) begin
        r_counter <= '0;
      end else begin
        r_counter <= r_counter + 1'b1;
      end

      if (w_led_we) begin
        r_ledr <= DataOut[9:0];
      end

      if (w_err_set) begin
        r_mem_error <= 1'b1;
      end

      r_sw_meta <= SW;
      r_sw_sync <= r_sw_meta;
    end
  end

  assign DataIn   = r_s2_data;
  assign DataDone = r_s2_valid;
  assign LEDR     = r_ledr;
  assign MemError = r_mem_error;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_mem_ctrl
// Purpose  : Self-checking bench for data_mem_ctrl. A vector table drives the
//            RAM/LED traffic; hand-written sequences cover the counter wrap,
//            switch synchroniser, error flag and reset-discard cases. Every
//            load pushes its expected data and due cycle onto a scoreboard
//            that a negedge monitor pops when DataDone should appear.
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_mem_ctrl;

  localparam logic [15:0] c_led = 16'h1000;
  localparam logic [15:0] c_cnt = 16'h2000;
  localparam logic [15:0] c_sw  = 16'h3000;

  logic        Clock;
  logic        Reset;
  logic [15:0] DataAddr;
  logic [15:0] DataOut;
  logic        WriteData;
  logic        ReadData;
  logic [9:0]  SW;
  logic [15:0] DataIn;
  logic        DataDone;
  logic [9:0]  LEDR;
  logic        MemError;

  data_mem_ctrl #(
    .WORD_SIZE (16),
    .DEPTH     (256),
    .LED_ADDR  (c_led),
    .CNT_ADDR  (c_cnt),
    .SW_ADDR   (c_sw)
  ) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .DataAddr  (DataAddr),
    .DataOut   (DataOut),
    .WriteData (WriteData),
    .ReadData  (ReadData),
    .SW        (SW),
    .DataIn    (DataIn),
    .DataDone  (DataDone),
    .LEDR      (LEDR),
    .MemError  (MemError)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  always @(posedge Clock) cyc <= cyc + 1;

  typedef struct packed {
    int          due;
    logic [15:0] data;
  } exp_t;

  exp_t sb[$];

  typedef struct packed {
    logic        rd;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic [9:0]  ledr;
    logic        err;
  } vec_t;

  vec_t vecs[$];

  // Monitor: a load is due exactly two edges after its request edge; any
  // other cycle must show DataDone=0 and DataIn=0.
  always @(negedge Clock) begin
    if (!Reset) begin
      tests++;
      if (sb.size() > 0 && sb[0].due == cyc) begin
        if (DataDone !== 1'b1 || DataIn !== sb[0].data) begin
          fails++;
          $display("FAIL load@%0d: DataDone=%b DataIn=%h, want DataDone=1 DataIn=%h",
                   cyc, DataDone, DataIn, sb[0].data);
        end
        void'(sb.pop_front());
      end else if (DataDone !== 1'b0 || DataIn !== 16'h0) begin
        fails++;
        $display("FAIL idle@%0d: DataDone=%b DataIn=%h, want DataDone=0 DataIn=0000",
                 cyc, DataDone, DataIn);
      end
    end
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Drive one request cycle; if push is set the load's result is expected.
  task automatic op(input logic rd, input logic wr, input logic [15:0] addr,
                    input logic [15:0] wdata, input logic [15:0] rdata, input logic push);
    ReadData  = rd;
    WriteData = wr;
    DataAddr  = addr;
    DataOut   = wdata;
    if (rd && push) sb.push_back('{due: cyc + 2, data: rdata});
    @(posedge Clock);
    #1;
    ReadData  = 1'b0;
    WriteData = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) op(1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 1'b0);
  endtask

  initial begin
    Reset     = 1'b1;
    DataAddr  = '0;
    DataOut   = '0;
    WriteData = 1'b0;
    ReadData  = 1'b0;
    SW        = '0;
    repeat (3) @(posedge Clock);
    #1;
    check("rst_datain",   DataIn, 16'h0);
    check("rst_datadone", {15'h0, DataDone}, 16'h0);
    Reset = 1'b0;
    check("rst_ledr",     {6'h0, LEDR}, 16'h0);
    check("rst_memerror", {15'h0, MemError}, 16'h0);

    // rd, wr, addr, wdata, expected rdata, expected LEDR/MemError after edge
    vecs.push_back('{1'b0, 1'b1, 16'd5,  16'hBEEF, 16'h0,    10'h000, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 16'd5,  16'h0,    16'hBEEF, 10'h000, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 16'd0,  16'h0,    16'h0,    10'h000, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 16'd0,  16'h0,    16'h0,    10'h000, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 16'd0,  16'h0011, 16'h0,    10'h000, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 16'd1,  16'h0022, 16'h0,    10'h000, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 16'd2,  16'h0033, 16'h0,    10'h000, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 16'd3,  16'h0044, 16'h0,    10'h000, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 16'd0,  16'h0,    16'h0011, 10'h000, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 16'd1,  16'h0,    16'h0022, 10'h000, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 16'd2,  16'h0,    16'h0033, 10'h000, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 16'd3,  16'h0,    16'h0044, 10'h000, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 16'd0,  16'h0,    16'h0,    10'h000, 1'b0});
    vecs.push_back('{1'b0, 1'b1, c_led,  16'hFFFF, 16'h0,    10'h3FF, 1'b0});
    vecs.push_back('{1'b1, 1'b0, c_led,  16'h0,    16'h03FF, 10'h3FF, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 16'd255,16'hA5A5, 16'h0,    10'h3FF, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 16'd255,16'h0,    16'hA5A5, 10'h3FF, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 16'd0,  16'h0,    16'h0,    10'h3FF, 1'b0});
    // Simultaneous load/store: old data returned, store lands, flag sets.
    vecs.push_back('{1'b1, 1'b1, 16'd5,  16'h5555, 16'hBEEF, 10'h3FF, 1'b1});
    vecs.push_back('{1'b1, 1'b0, 16'd5,  16'h0,    16'h5555, 10'h3FF, 1'b1});
    vecs.push_back('{1'b0, 1'b0, 16'd0,  16'h0,    16'h0,    10'h3FF, 1'b1});
    vecs.push_back('{1'b0, 1'b0, 16'd0,  16'h0,    16'h0,    10'h3FF, 1'b1});

    for (int i = 0; i < vecs.size(); i++) begin
      op(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].rdata, 1'b1);
      check($sformatf("vec%0d_ledr", i), {6'h0, LEDR}, {6'h0, vecs[i].ledr});
      check($sformatf("vec%0d_err", i),  {15'h0, MemError}, {15'h0, vecs[i].err});
    end

    // Counter: cleared by a store, read ten cycles later, then after a wrap.
    op(1'b0, 1'b1, c_cnt, 16'h1234, 16'h0, 1'b0);
    idle(9);
    op(1'b1, 1'b0, c_cnt, 16'h0, 16'd9, 1'b1);
    idle(65535);
    op(1'b1, 1'b0, c_cnt, 16'h0, 16'd9, 1'b1);
    idle(3);

    // Switches through the synchroniser, then error-flag cases.
    SW = 10'h2A5;
    idle(2);
    op(1'b1, 1'b0, c_sw, 16'h0, 16'h02A5, 1'b1);
    op(1'b0, 1'b1, c_sw, 16'hFFFF, 16'h0, 1'b0);
    check("sw_write_err", {15'h0, MemError}, 16'h1);
    op(1'b1, 1'b0, 16'h0F00, 16'h0, 16'h0, 1'b1);
    idle(3);
    check("illegal_err", {15'h0, MemError}, 16'h1);

    // Reset with a load in flight: result discarded, RAM retained.
    op(1'b0, 1'b1, 16'd7, 16'h1234, 16'h0, 1'b0);
    op(1'b1, 1'b0, 16'd7, 16'h0, 16'h0, 1'b0);
    Reset = 1'b1;
    #1;
    check("inflight_rst_done", {15'h0, DataDone}, 16'h0);
    @(posedge Clock);
    #1;
    Reset = 1'b0;
    check("post_rst_datain", DataIn, 16'h0);
    check("post_rst_ledr",   {6'h0, LEDR}, 16'h0);
    check("post_rst_err",    {15'h0, MemError}, 16'h0);
    idle(4);
    op(1'b1, 1'b0, 16'd7, 16'h0, 16'h1234, 1'b1);
    idle(4);

    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d loads outstanding, want 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Hard bound in case the sequence above ever stalls.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit, want completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
